// File: rtl/trap_controller.sv
// Machine-mode trap entry/return sequencer: capture -> drain memory -> commit CSRs -> redirect fetch.
// Optional VECTORED_TRAP_EN: vectored interrupt targets when mtvec[1:0] == 2'b01.
module trap_controller #(
  parameter int unsigned DRAIN_MAX     = 16,
  parameter logic [31:0] MCAUSE_ECALL  = 32'd11,
  parameter logic [31:0] MCAUSE_EBREAK = 32'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        interrupt_pending,
  input  logic [31:0] interrupt_cause,
  input  logic        ecall_exception,
  input  logic        ebreak_exception,
  input  logic        mret_instruction,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        mem_busy,
  input  logic        redirect_ready,
  output logic        pipeline_stall,
  output logic        flush_pipeline,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mepc_we,
  output logic [31:0] mepc_wdata,
  output logic        mcause_we,
  output logic [31:0] mcause_wdata,
  output logic        mstatus_trap_enter,
  output logic        mstatus_trap_return,
  output logic        interrupt_ack,
  output logic        drain_timeout
);

  typedef enum logic [1:0] {StIdle, StDrain, StCommit, StRedirect} state_e;
  typedef enum logic [1:0] {KindIrq, KindExc, KindMret} kind_e;

  localparam logic [7:0] DrainLast = 8'(DRAIN_MAX - 1);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] target_q, target_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        holdoff_q, holdoff_d;
  logic        timeout_q, timeout_d;

  logic        stall_q, stall_d;
  logic        flush_q, flush_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rpc_q, rpc_d;
  logic        mepc_we_q, mepc_we_d;
  logic [31:0] mepc_wdata_q, mepc_wdata_d;
  logic        mcause_we_q, mcause_we_d;
  logic [31:0] mcause_wdata_q, mcause_wdata_d;
  logic        enter_q, enter_d;
  logic        return_q, return_d;
  logic        ack_q, ack_d;

  logic [31:0] trap_base;
  logic [31:0] irq_target;
  logic        irq_take;
  logic        commit_trap;
  logic        unused_mtvec_mode;

  assign trap_base         = {mtvec[31:2], 2'b00};
  assign irq_take          = interrupt_pending & mstatus_mie;
  assign unused_mtvec_mode = ^mtvec[1:0];

`ifdef VECTORED_TRAP_EN
  assign irq_target = (mtvec[1:0] == 2'b01) ?
                      trap_base + {25'd0, interrupt_cause[4:0], 2'b00} : trap_base;
`else
  assign irq_target = trap_base;
`endif

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    pc_d      = pc_q;
    cause_d   = cause_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    holdoff_d = 1'b0;
    timeout_d = timeout_q;

    unique case (state_q)
      StIdle: begin
        // holdoff_q blocks re-capture of the stale EX contents right after a redirect
        if (ex_valid && !holdoff_q &&
            (irq_take || ebreak_exception || ecall_exception || mret_instruction)) begin
          state_d = StDrain;
          pc_d    = ex_pc;
          cnt_d   = 8'd0;
          if (irq_take) begin
            kind_d   = KindIrq;
            cause_d  = interrupt_cause;
            target_d = irq_target;
          end else if (ebreak_exception) begin
            kind_d   = KindExc;
            cause_d  = MCAUSE_EBREAK;
            target_d = trap_base;
          end else if (ecall_exception) begin
            kind_d   = KindExc;
            cause_d  = MCAUSE_ECALL;
            target_d = trap_base;
          end else begin
            kind_d   = KindMret;
            cause_d  = 32'd0;
            target_d = mepc;
          end
        end
      end
      StDrain: begin
        if (!mem_busy) begin
          state_d = StCommit;
        end else if (cnt_q == DrainLast) begin
          state_d   = StCommit;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StCommit: state_d = StRedirect;
      StRedirect: begin
        if (redirect_ready) begin
          state_d   = StIdle;
          holdoff_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the state they describe.
  always_comb begin
    commit_trap    = (state_d == StCommit) && (kind_d != KindMret);
    stall_d        = (state_d != StIdle);
    flush_d        = (state_d == StCommit);
    rvalid_d       = (state_d == StRedirect);
    rpc_d          = rvalid_d ? target_d : 32'd0;
    mepc_we_d      = commit_trap;
    mepc_wdata_d   = commit_trap ? pc_d : 32'd0;
    mcause_we_d    = commit_trap;
    mcause_wdata_d = commit_trap ? cause_d : 32'd0;
    enter_d        = commit_trap;
    return_d       = (state_d == StCommit) && (kind_d == KindMret);
    ack_d          = (state_d == StCommit) && (kind_d == KindIrq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      kind_q         <= KindExc;
      pc_q           <= 32'd0;
      cause_q        <= 32'd0;
      target_q       <= 32'd0;
      cnt_q          <= 8'd0;
      holdoff_q      <= 1'b0;
      timeout_q      <= 1'b0;
      stall_q        <= 1'b0;
      flush_q        <= 1'b0;
      rvalid_q       <= 1'b0;
      rpc_q          <= 32'd0;
      mepc_we_q      <= 1'b0;
      mepc_wdata_q   <= 32'd0;
      mcause_we_q    <= 1'b0;
      mcause_wdata_q <= 32'd0;
      enter_q        <= 1'b0;
      return_q       <= 1'b0;
      ack_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      pc_q           <= pc_d;
      cause_q        <= cause_d;
      target_q       <= target_d;
      cnt_q          <= cnt_d;
      holdoff_q      <= holdoff_d;
      timeout_q      <= timeout_d;
      stall_q        <= stall_d;
      flush_q        <= flush_d;
      rvalid_q       <= rvalid_d;
      rpc_q          <= rpc_d;
      mepc_we_q      <= mepc_we_d;
      mepc_wdata_q   <= mepc_wdata_d;
      mcause_we_q    <= mcause_we_d;
      mcause_wdata_q <= mcause_wdata_d;
      enter_q        <= enter_d;
      return_q       <= return_d;
      ack_q          <= ack_d;
    end
  end

  assign pipeline_stall      = stall_q;
  assign flush_pipeline      = flush_q;
  assign redirect_valid      = rvalid_q;
  assign redirect_pc         = rpc_q;
  assign mepc_we             = mepc_we_q;
  assign mepc_wdata          = mepc_wdata_q;
  assign mcause_we           = mcause_we_q;
  assign mcause_wdata        = mcause_wdata_q;
  assign mstatus_trap_enter  = enter_q;
  assign mstatus_trap_return = return_q;
  assign interrupt_ack       = ack_q;
  assign drain_timeout       = timeout_q;

endmodule
